// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder and register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_SEND = 2'd2
    } state_t;

    // Command byte: bit 7 selects write (1) or read (0), bits [6:0] are the address.
    localparam int CMD_WR_BIT = 7;

    // Byte returned for every byte of a read from an unmapped address.
    localparam logic [7:0] RD_BAD_BYTE_DFLT = 8'hEE;

    // Player register map in the 1-byte configuration.
    localparam logic [6:0] REG_NOTE_ON  = 7'd5;
    localparam logic [6:0] REG_NOTE_OFF = 7'd6;
    localparam logic [6:0] REG_ID       = 7'd7;

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte timeout: loadable down-counter that flags TIMEOUT_CYCLES silent cycles.
// Latency: expired is combinational from the count, asserted on the TIMEOUT_CYCLES-th silent edge.
// Backpressure: none; restart always wins over expiry in the same cycle.
// Ports: clk96m/rst_n clock and async reset; restart reloads the count; run enables
// counting; expired pulses when run is set and the count has reached zero.
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 960000
) (
    input  logic clk96m,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT_CYCLES-1 so that the zero check fires on the
    // TIMEOUT_CYCLES-th consecutive edge without a restart.
    always_ff @(posedge clk96m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CW'(TIMEOUT_CYCLES - 1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && !restart && (cnt == '0);

endmodule

// File: rtl/uart_cmd_regs.sv
// UART command decoder: multi-byte writable control registers plus read-only status read-back.
// Latency: write visible 1 cycle after the last data byte; read tx_valid 1 cycle after the command.
// Backpressure: tx_valid/tx_data held until tx_ready; rx bytes arriving during a read are dropped and counted.
// Ports: clk96m/rst_n clock and async reset; rx_data/rx_valid byte stream in;
// tx_data/tx_valid/tx_ready byte stream out; ctrl_regs/ctrl_wr_strobe control outputs;
// status_in status words; bad_cmd error pulse; rx_drop_cnt saturating drop counter.
module uart_cmd_regs
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_REGS       = 8,
    parameter int         NUM_STAT       = 4,
    parameter int         REG_BYTES      = 1,
    parameter int         TIMEOUT_CYCLES = 960000,
    parameter logic [7:0] RD_BAD_BYTE    = RD_BAD_BYTE_DFLT
) (
    input  logic                          clk96m,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REGS*8*REG_BYTES-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]           ctrl_wr_strobe,
    input  logic [NUM_STAT*8*REG_BYTES-1:0] status_in,
    output logic                          bad_cmd,
    output logic [7:0]                    rx_drop_cnt
);

    localparam int         REG_W    = 8 * REG_BYTES;
    localparam logic [1:0] LAST_IDX = 2'(REG_BYTES - 1);

    state_t           state;
    logic [6:0]       addr;
    logic [1:0]       wr_idx;
    logic [1:0]       tx_idx;
    logic [REG_W-1:0] stage;
    logic [REG_W-1:0] tx_shift;

    logic [6:0]       rx_addr;
    logic             rx_is_wr;
    logic [REG_W-1:0] wr_val;
    logic [REG_W-1:0] rd_word;
    logic             rd_hit;
    logic             wr_hit;
    logic             tmo_restart;
    logic             tmo_run;
    logic             tmo_expired;

    assign rx_addr  = rx_data[6:0];
    assign rx_is_wr = rx_data[CMD_WR_BIT];

    // Staged value including the byte arriving this cycle (MSB byte first).
    assign wr_val = (stage << 8) | REG_W'(rx_data);

    // Current output byte is always the top byte of the shift register.
    assign tx_data = tx_shift[REG_W-1 -: 8];

    // Read decode on the incoming command address; status words are sampled
    // on the same edge that accepts the command.
    always_comb begin
        rd_word = {REG_BYTES{RD_BAD_BYTE}};
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_addr == 7'(i)) begin
                rd_word = ctrl_regs[i*REG_W +: REG_W];
                rd_hit  = 1'b1;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (rx_addr == 7'(NUM_REGS + j)) begin
                rd_word = status_in[j*REG_W +: REG_W];
                rd_hit  = 1'b1;
            end
        end
    end

    // Only control registers are writable; status addresses count as unmapped.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) begin
                wr_hit = 1'b1;
            end
        end
    end

    // Every accepted byte of a write (command included) restarts the timeout.
    assign tmo_restart = rx_valid && (((state == ST_IDLE) && rx_is_wr) || (state == ST_WR_DATA));
    assign tmo_run     = (state == ST_WR_DATA);

    cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk96m  (clk96m),
        .rst_n   (rst_n),
        .restart (tmo_restart),
        .run     (tmo_run),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk96m or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr           <= '0;
            wr_idx         <= '0;
            tx_idx         <= '0;
            stage          <= '0;
            tx_shift       <= '0;
            tx_valid       <= 1'b0;
            ctrl_regs      <= '0;
            ctrl_wr_strobe <= '0;
            bad_cmd        <= 1'b0;
            rx_drop_cnt    <= '0;
        end else begin
            ctrl_wr_strobe <= '0;
            bad_cmd        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_is_wr) begin
                            addr   <= rx_addr;
                            wr_idx <= '0;
                            stage  <= '0;
                            state  <= ST_WR_DATA;
                        end else begin
                            tx_shift <= rd_word;
                            tx_idx   <= '0;
                            tx_valid <= 1'b1;
                            bad_cmd  <= !rd_hit;
                            state    <= ST_RD_SEND;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (rx_valid) begin
                        stage <= wr_val;
                        if (wr_idx == LAST_IDX) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr == 7'(i)) begin
                                    ctrl_regs[i*REG_W +: REG_W] <= wr_val;
                                    ctrl_wr_strobe[i]           <= 1'b1;
                                end
                            end
                            bad_cmd <= !wr_hit;
                            state   <= ST_IDLE;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end else if (tmo_expired) begin
                        stage   <= '0;
                        bad_cmd <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_RD_SEND: begin
                    // tx_valid is held high for the whole of this state.
                    if (tx_ready) begin
                        tx_shift <= tx_shift << 8;
                        if (tx_idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                    if (rx_valid && (rx_drop_cnt != 8'hFF)) begin
                        rx_drop_cnt <= rx_drop_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_regs.sv
module tb_uart_cmd_regs;
    import uart_cmd_pkg::*;

    localparam int NUM_REGS  = 8;
    localparam int NUM_STAT  = 4;
    localparam int REG_BYTES = 2;
    localparam int TMO       = 100;

    logic           clk96m = 1'b0;
    logic           rst_n  = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic [127:0]   ctrl_regs;
    logic [7:0]     ctrl_wr_strobe;
    logic [63:0]    status_in = {16'hC0DE, 16'h7777, 16'h1357, 16'hBEEF};
    logic           bad_cmd;
    logic [7:0]     rx_drop_cnt;

    always #5 clk96m = ~clk96m;

    uart_cmd_regs #(
        .NUM_REGS       (NUM_REGS),
        .NUM_STAT       (NUM_STAT),
        .REG_BYTES      (REG_BYTES),
        .TIMEOUT_CYCLES (TMO),
        .RD_BAD_BYTE    (8'hEE)
    ) dut (
        .clk96m         (clk96m),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .ctrl_regs      (ctrl_regs),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .status_in      (status_in),
        .bad_cmd        (bad_cmd),
        .rx_drop_cnt    (rx_drop_cnt)
    );

    typedef struct packed {
        logic [7:0]   strobe;
        logic [127:0] regs;
    } wr_ev_t;

    wr_ev_t       wr_q[$];
    logic [7:0]   tx_q[$];
    int           bad_exp = 0;
    logic [127:0] model = '0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk96m) begin
        if (rst_n === 1'b1) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_byte", {120'd0, tx_data}, 128'hFFFF);
                end else begin
                    chk("tx_byte", {120'd0, tx_data}, {120'd0, tx_q.pop_front()});
                end
            end
            if (ctrl_wr_strobe != 8'h00) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected_strobe", {120'd0, ctrl_wr_strobe}, 128'd0);
                end else begin
                    wr_ev_t ev;
                    ev = wr_q.pop_front();
                    chk("wr_strobe", {120'd0, ctrl_wr_strobe}, {120'd0, ev.strobe});
                    chk("wr_regs", ctrl_regs, ev.regs);
                end
            end
            if (bad_cmd) begin
                chk("bad_cmd_expected", {127'd0, (bad_exp > 0)}, 128'd1);
                if (bad_exp > 0) bad_exp--;
            end
        end
    end

    // Drives one byte for exactly one clock; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk96m);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wr_reg(input logic [6:0] a, input logic [15:0] v);
        wr_ev_t ev;
        model[a*16 +: 16] = v;
        ev.strobe = 8'd1 << a;
        ev.regs   = model;
        wr_q.push_back(ev);
        send({1'b1, a});
        send(v[15:8]);
        send(v[7:0]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_valid || tx_q.size() != 0) && n < 200) begin
            @(posedge clk96m);
            n++;
        end
        #1;
        chk("read_completes_in_budget", {127'd0, (n < 200)}, 128'd1);
    endtask

    task automatic rd_reg(input logic [6:0] a, input logic [15:0] v, input bit bad);
        tx_q.push_back(v[15:8]);
        tx_q.push_back(v[7:0]);
        if (bad) bad_exp++;
        send({1'b0, a});
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl_regs"}, ctrl_regs, 128'd0);
        chk({tag, "_strobe"}, {120'd0, ctrl_wr_strobe}, 128'd0);
        chk({tag, "_tx_valid"}, {127'd0, tx_valid}, 128'd0);
        chk({tag, "_tx_data"}, {120'd0, tx_data}, 128'd0);
        chk({tag, "_bad_cmd"}, {127'd0, bad_cmd}, 128'd0);
        chk({tag, "_drop_cnt"}, {120'd0, rx_drop_cnt}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk96m);
        @(negedge clk96m) rst_n = 1'b1;
        @(posedge clk96m); #1;

        // Writes: note_on register, then register 0 back-to-back.
        wr_reg(REG_NOTE_ON, 16'h1234);
        wr_reg(7'd0, 16'hABCD);
        repeat (2) @(posedge clk96m); #1;
        chk("regs_after_writes", ctrl_regs, model);

        // Stalled read-back of register 5 with dropped rx bytes.
        tx_ready = 1'b0;
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        send(8'h05);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk96m);
            chk("stall_tx_valid", {127'd0, tx_valid}, 128'd1);
            chk("stall_tx_data", {120'd0, tx_data}, 128'h12);
        end
        @(posedge clk96m); #1;
        for (int i = 0; i < 3; i++) send(8'h5A);
        @(negedge clk96m);
        chk("drop_cnt_3", {120'd0, rx_drop_cnt}, 128'd3);
        @(posedge clk96m); #1;
        tx_ready = 1'b1;
        wait_idle();
        @(negedge clk96m);
        chk("tx_valid_low_after_read", {127'd0, tx_valid}, 128'd0);
        @(posedge clk96m); #1;

        // Status reads, first and last status word.
        rd_reg(7'h08, 16'hBEEF, 1'b0);
        rd_reg(7'h0B, 16'hC0DE, 1'b0);
        // Unmapped reads: first address past the status block and the top address.
        rd_reg(7'h0C, 16'hEEEE, 1'b1);
        rd_reg(7'h7F, 16'hEEEE, 1'b1);

        // Write to a status address: error, no strobe, no change.
        bad_exp++;
        send(8'h88);
        send(8'h11);
        send(8'h22);
        repeat (2) @(posedge clk96m); #1;
        chk("regs_after_bad_write", ctrl_regs, model);

        // Timeout after one data byte.
        bad_exp++;
        send(8'h83);
        send(8'hAA);
        repeat (TMO - 1) @(posedge clk96m);
        @(negedge clk96m);
        chk("timeout_not_early", {127'd0, bad_cmd}, 128'd0);
        @(negedge clk96m);
        chk("timeout_fires", {127'd0, bad_cmd}, 128'd1);
        @(posedge clk96m); #1;
        chk("regs_after_timeout", ctrl_regs, model);
        wr_reg(7'd3, 16'h0102);
        rd_reg(7'd3, 16'h0102, 1'b0);

        // Drop counter saturation during a long stalled read.
        tx_ready = 1'b0;
        tx_q.push_back(8'hAB);
        tx_q.push_back(8'hCD);
        send(8'h00);
        for (int i = 0; i < 300; i++) send(8'h33);
        @(negedge clk96m);
        chk("drop_cnt_saturated", {120'd0, rx_drop_cnt}, 128'd255);
        @(posedge clk96m); #1;
        tx_ready = 1'b1;
        wait_idle();

        // Async reset between clock edges mid-write.
        send(8'h86);
        send(8'h77);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        model = '0;
        @(negedge clk96m) rst_n = 1'b1;
        @(posedge clk96m); #1;
        wr_reg(REG_NOTE_OFF, 16'h9988);
        repeat (2) @(posedge clk96m); #1;
        chk("regs_after_reset_write", ctrl_regs, model);
        rd_reg(REG_NOTE_OFF, 16'h9988, 1'b0);

        repeat (5) @(posedge clk96m); #1;
        chk("wr_q_drained", 128'(wr_q.size()), 128'd0);
        chk("tx_q_drained", 128'(tx_q.size()), 128'd0);
        chk("bad_cmd_all_seen", 128'(bad_exp), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_regs.md
Name: uart_cmd_regs

Overview:
- Parametrised UART command decoder and register file; replaces the hard-coded note_on/note_off/id decoder in the SD player top.
- Sits between uart_ss (byte-stream rx/tx) and the player/SD logic.
- Provides N multi-byte control registers with write strobes and read-only status registers with true read-back (tx ready handshake).
- Adds an inter-byte timeout on partial writes and error signalling.

Parameters:
- NUM_REGS, 8, number of writable control registers, addresses 0..NUM_REGS-1.
- NUM_STAT, 4, number of read-only status registers, addresses NUM_REGS..NUM_REGS+NUM_STAT-1; NUM_REGS+NUM_STAT <= 128.
- REG_BYTES, 1, bytes per register, 1..4; REG_W = 8*REG_BYTES.
- TIMEOUT_CYCLES, 960000, max clk96m cycles between bytes of a write (10 ms at 96 MHz); must be >= 2.
- RD_BAD_BYTE, 8'hEE, byte returned for each byte of a read to an unmapped address.

Ports:
- clk96m, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx_data, in, 8, received byte from uart_ss.
- rx_valid, in, 1, one-cycle pulse: rx_data valid.
- tx_data, out, 8, byte to transmit.
- tx_valid, out, 1, tx_data valid; held until tx_ready.
- tx_ready, in, 1, uart_ss accepts byte when tx_valid && tx_ready.
- ctrl_regs, out, NUM_REGS*REG_W, register i at bits [i*REG_W +: REG_W].
- ctrl_wr_strobe, out, NUM_REGS, one-cycle pulse per register written.
- status_in, in, NUM_STAT*REG_W, status word j at [j*REG_W +: REG_W].
- bad_cmd, out, 1, one-cycle pulse on error (unmapped address or timeout).
- rx_drop_cnt, out, 8, saturating count of bytes dropped while reading.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ctrl_regs=0, ctrl_wr_strobe=0, tx_valid=0, tx_data=0, bad_cmd=0, rx_drop_cnt=0, timeout counter=0. A reset mid-transaction discards all partial data; no strobe is issued.
- Command byte: bit7=1 is a write, bit7=0 is a read; bits[6:0] are the address.
- States: IDLE, WR_DATA, RD_SEND.
- IDLE + rx_valid:
  - Write command: latch address, clear byte index and timeout counter, go to WR_DATA.
  - Read command: on the same edge, load the tx shift register with the addressed register. Control addresses read back the current ctrl_regs value; status addresses sample status_in on that edge. Unmapped addresses load REG_BYTES copies of RD_BAD_BYTE and pulse bad_cmd. Go to RD_SEND; tx_valid=1 from the next cycle.
- WR_DATA:
  - Each rx_valid captures one byte, MSB byte first, into a staging register and resets the timeout counter.
  - On the edge capturing byte REG_BYTES-1: if the address < NUM_REGS, ctrl_regs[addr] takes the staged value and ctrl_wr_strobe[addr]=1. Both are visible in the following cycle; the strobe lasts exactly 1 cycle. Otherwise, pulse bad_cmd and leave the registers unchanged. Return to IDLE.
  - No rx_valid for TIMEOUT_CYCLES consecutive cycles: discard partial data, pulse bad_cmd, go to IDLE.
  - rx_valid in the timeout cycle: the byte wins and the timeout is ignored.
- RD_SEND:
  - tx_data = current MSB byte.
  - On tx_valid && tx_ready: shift; after the last byte is accepted, tx_valid=0 next cycle and go to IDLE.
  - tx_valid never drops while waiting for tx_ready.
  - rx_valid in RD_SEND: byte dropped, rx_drop_cnt+1, saturating at 255.
- Back-to-back: a command byte arriving the cycle after returning to IDLE is accepted normally. Zero bubble is not required between transactions; the IDLE cycle is the only overhead.
- Minimum read latency: command edge to first tx_valid = 1 cycle.
- Registers in the 1-byte configuration are bit-compatible with the current map (addr 5 note_on, 6 note_off, 7 id).

Decomposition:
- Shared package/header uart_cmd_pkg:
  - State encodings (ST_IDLE, ST_WR_DATA, ST_RD_SEND).
  - CMD_WR_BIT=7.
  - Default RD_BAD_BYTE.
  - Address constants for the player map (REG_NOTE_ON=5, REG_NOTE_OFF=6, REG_ID=7).
- One natural sub-module, cmd_timeout: a loadable down-counter with a restart input and an expired output pulse, parametrised by TIMEOUT_CYCLES. Everything else stays in uart_cmd_regs.

Test Plan:
- REG_BYTES=2: send 0x85,0x12,0x34 → cycle after 0x34: ctrl_regs[5]=16'h1234, ctrl_wr_strobe=8'b0010_0000 for exactly 1 cycle; other registers 0.
- Read-back: after the above, send 0x05 with tx_ready stalled 10 cycles → tx_valid held with tx_data=0x12; after accept, 0x34; then tx_valid=0; IDLE.
- Status read: NUM_REGS=8, status_in word0=16'hBEEF, send 0x08 → tx 0xBE,0xEF. Send 0x7F → tx 0xEE,0xEE, bad_cmd pulse.
- Timeout: TIMEOUT_CYCLES=100, send 0x83,0xAA, then silence 100 cycles → bad_cmd pulse, ctrl_regs[3] unchanged (0), no strobe. Next 0x83,0x01,0x02 writes 16'h0102.
- Drop counter: during a stalled read, inject 3 rx_valid bytes → rx_drop_cnt=3; 300 bytes → saturates at 255.
- Async reset: assert rst_n=0 mid-write after the first data byte, between clock edges → all outputs 0 immediately. After release, a full write works and the old partial byte is not applied.
